spi_master_engine: RTL and testbench
====================================

# spi_master_engine

Active SPI initiator for the MITM design. It drives SS, SCLK and MOSI itself and captures MISO, so the design can originate transactions toward a slave instead of only snooping and overriding them. Its bus conventions match what the passive snoop path expects: SS idle-low and active-high, data sampled on SCLK rise and changed on SCLK fall, MSB first. Its outputs can feed the fake_* inputs of the output multiplexer.

## Interface
- DATA_SIZE, 8: bits per transaction; must be ≥ 1.
- CLK_DIV, 4: sys_clk cycles per SCLK half-period; must be ≥ 1.
- sys_clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a transaction; sampled only in IDLE.
- tx_data  in  DATA_SIZE  word to send; latched on the accepting edge.
- busy  out  1  high from the accepting edge until the engine can accept again.
- done_sig  out  1  one-cycle pulse when a transaction completes.
- rx_data  out  DATA_SIZE  last received word; holds until the next completion.
- ss_out  out  1  slave select, active-high.
- sclk_out  out  1  serial clock, idle low.
- mosi_out  out  1  serial data to the slave.
- miso_in  in  1  serial data from the slave; the block does not synchronize it.

## Operation
- Reset (rst_n=0, asynchronous) drives every output to 0: busy, done_sig, rx_data, ss_out, sclk_out, mosi_out. The state machine goes to IDLE, and the internal shift register and counters clear.
- States: IDLE, SETUP, HIGH, LOW, HOLD, GAP. One half-period counter runs 0..CLK_DIV-1, and one bit counter runs 0..DATA_SIZE-1.
- IDLE, with start=1:
  - latch tx_data into the shift register;
  - set ss_out=1, busy=1, mosi_out=tx_data[DATA_SIZE-1];
  - go to SETUP.
- IDLE, with start=0: all outputs hold.
- SETUP: wait CLK_DIV cycles with sclk_out=0. On the exit edge, set sclk_out=1, sample miso_in into the LSB of the receive shift register, and go to HIGH.
- HIGH, after CLK_DIV cycles, sets sclk_out=0 on the exit edge. Then:
  - if bits remain, increment the bit count, put the next bit (MSB-first) on mosi_out at that same edge, and go to LOW;
  - if this was the last bit, go to HOLD with mosi_out unchanged.
- LOW: after CLK_DIV cycles, set sclk_out=1, sample miso_in, and go to HIGH.
- HOLD: after CLK_DIV cycles with sclk_out=0, on the exit edge:
  - set ss_out=0 and mosi_out=0;
  - load rx_data from the receive shift register;
  - pulse done_sig for one cycle;
  - go to GAP.
- GAP: wait CLK_DIV cycles with ss_out=0. On the exit edge set busy=0 and go to IDLE. This guarantees an SS-low time that the edge detectors can see.
- start outside IDLE is ignored; there is no queueing.
- Received word: the first sampled bit ends up in rx_data[DATA_SIZE-1].
- DATA_SIZE=1: SETUP → HIGH → HOLD, with no LOW state.
- Reset mid-transaction aborts immediately:
  - ss_out and sclk_out drop asynchronously;
  - rx_data clears to 0;
  - no done_sig is produced;
  - the next start after rst_n returns high starts a fresh transaction.

## Timing
- The accepting edge is T0. ss_out rises at T0.
- SCLK rising edges fall at T0 + CLK_DIV·(2k+1), for k = 0..DATA_SIZE-1.
- SCLK falling edges fall at T0 + CLK_DIV·(2k+2).
- ss_out falls at T0 + CLK_DIV·(2·DATA_SIZE+1). done_sig is high and rx_data is valid in the cycle that starts at that edge.
- busy falls at T0 + CLK_DIV·(2·DATA_SIZE+2).
- If start is held high, the next accepting edge is the first edge after busy falls. SS is low between transactions for CLK_DIV+1 cycles.
- MOSI changes only at T0, at SCLK-falling edges, and when SS falls. MISO is sampled only at SCLK-rising edges.
- The slave must update MISO at least one sys_clk before each SCLK rise.

## Test plan
- **Loopback.** DATA_SIZE=8, CLK_DIV=2, miso_in tied to mosi_out, tx_data=0xA5, start pulsed for 1 cycle. Required:
  - exactly 8 sclk_out rising edges;
  - ss_out high for 34 cycles;
  - done_sig pulse coincides with ss_out falling;
  - rx_data=0xA5;
  - busy high for 36 cycles.
- **Constant MISO.** miso_in=1 with tx_data=0x00 → rx_data=0xFF and mosi_out stays 0. Then miso_in=0 with tx_data=0xFF → rx_data=0x00.
- **MISO pattern.** A slave model drives 0x3C MSB-first, changing on sclk_out falling edges. Required: rx_data=0x3C, and mosi_out carries each tx_data bit stable across its rising edge.
- **start while busy.** Pulse start with tx_data=0x11 at T0+10 during a 0xA5 transaction. Required: it is ignored, only one done_sig pulse occurs, and rx_data reflects the 0xA5 transaction only.
- **Reset mid-transaction.** Assert rst_n=0 for 3 cycles at T0+15. Required:
  - ss_out, sclk_out, busy and rx_data go to 0 with no clock edge needed;
  - no done_sig;
  - a new start for 0x5A then completes normally with rx_data=0x5A under loopback.
- **Back-to-back with start held high.** CLK_DIV=1, DATA_SIZE=4. Required: ss_out low for exactly 2 cycles between transactions, and each transaction is 9 cycles of ss_out high.

Source files
------------

// File: rtl/spi_master_engine.sv
// SPI initiator: drives SS (active-high), SCLK (idle low) and MOSI, captures MISO.
// Data is sampled on SCLK rise and changed on SCLK fall, MSB first.
module spi_master_engine #(
  parameter int DATA_SIZE = 8,
  parameter int CLK_DIV   = 4
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_SIZE-1:0] tx_data,
  output logic                 busy,
  output logic                 done_sig,
  output logic [DATA_SIZE-1:0] rx_data,
  output logic                 ss_out,
  output logic                 sclk_out,
  output logic                 mosi_out,
  input  logic                 miso_in
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [CW-1:0]        div_cnt_r, div_nxt_s;
  logic [BW-1:0]        bit_cnt_r, bit_nxt_s;
  // One register serves both directions: MSB shifts out, MISO shifts in at LSB.
  logic [DATA_SIZE-1:0] sh_r, sh_nxt_s, shifted_s;
  logic                 busy_nxt_s, done_nxt_s, ss_nxt_s, sclk_nxt_s, mosi_nxt_s;
  logic [DATA_SIZE-1:0] rx_nxt_s;
  logic                 div_end_s;

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_nxt_s  = state_r;
    div_nxt_s    = div_cnt_r;
    bit_nxt_s    = bit_cnt_r;
    sh_nxt_s     = sh_r;
    busy_nxt_s   = busy;
    done_nxt_s   = 1'b0;
    rx_nxt_s     = rx_data;
    ss_nxt_s     = ss_out;
    sclk_nxt_s   = sclk_out;
    mosi_nxt_s   = mosi_out;
    div_end_s    = (div_cnt_r == DIV_LAST);
    shifted_s    = sh_r << 1;
    shifted_s[0] = miso_in;

    case (state_r)
      IDLE: begin
        if (start) begin
          sh_nxt_s    = tx_data;
          ss_nxt_s    = 1'b1;
          busy_nxt_s  = 1'b1;
          mosi_nxt_s  = tx_data[DATA_SIZE-1];
          div_nxt_s   = '0;
          bit_nxt_s   = '0;
          state_nxt_s = SETUP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP, LOW: begin
        if (div_end_s) begin
          div_nxt_s   = '0;
          sclk_nxt_s  = 1'b1;
          sh_nxt_s    = shifted_s;
          state_nxt_s = HIGH;
        end else begin
          div_nxt_s = div_cnt_r + CW'(1);
        end
      end
      HIGH: begin
        if (div_end_s) begin
          div_nxt_s  = '0;
          sclk_nxt_s = 1'b0;
          if (bit_cnt_r == BIT_LAST) begin
            state_nxt_s = HOLD;
          end else begin
            // After the sampling shift, the MSB already holds the next bit to send.
            bit_nxt_s   = bit_cnt_r + BW'(1);
            mosi_nxt_s  = sh_r[DATA_SIZE-1];
            state_nxt_s = LOW;
          end
        end else begin
          div_nxt_s = div_cnt_r + CW'(1);
        end
      end
      HOLD: begin
        if (div_end_s) begin
          div_nxt_s   = '0;
          ss_nxt_s    = 1'b0;
          mosi_nxt_s  = 1'b0;
          rx_nxt_s    = sh_r;
          done_nxt_s  = 1'b1;
          state_nxt_s = GAP;
        end else begin
          div_nxt_s = div_cnt_r + CW'(1);
        end
      end
      GAP: begin
        if (div_end_s) begin
          div_nxt_s   = '0;
          busy_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          div_nxt_s = div_cnt_r + CW'(1);
        end
      end
      default: begin
        div_nxt_s   = '0;
        bit_nxt_s   = '0;
        busy_nxt_s  = 1'b0;
        ss_nxt_s    = 1'b0;
        sclk_nxt_s  = 1'b0;
        mosi_nxt_s  = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      div_cnt_r <= '0;
      bit_cnt_r <= '0;
      sh_r      <= '0;
      busy      <= 1'b0;
      done_sig  <= 1'b0;
      rx_data   <= '0;
      ss_out    <= 1'b0;
      sclk_out  <= 1'b0;
      mosi_out  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      div_cnt_r <= div_nxt_s;
      bit_cnt_r <= bit_nxt_s;
      sh_r      <= sh_nxt_s;
      busy      <= busy_nxt_s;
      done_sig  <= done_nxt_s;
      rx_data   <= rx_nxt_s;
      ss_out    <= ss_nxt_s;
      sclk_out  <= sclk_nxt_s;
      mosi_out  <= mosi_nxt_s;
    end
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// Bench for spi_master_engine: 8-bit/CLK_DIV=2 instance with selectable MISO source,
// plus a 4-bit/CLK_DIV=1 instance for back-to-back transfers.
module tb_spi_master_engine;

  logic sys_clk;
  logic rst_n;

  logic       start_a, busy_a, done_a, ss_a, sclk_a, mosi_a, miso_a;
  logic [7:0] tx_a, rx_a;
  logic       start_b, busy_b, done_b, ss_b, sclk_b, mosi_b;
  logic [3:0] tx_b, rx_b;

  logic [1:0] miso_mode;  // 0 loopback, 1 const 1, 2 const 0, 3 slave pattern
  logic [7:0] slave_pat;
  int         slave_idx;
  logic       slave_bit;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct { logic [7:0] tx; logic [7:0] rx; } sb_t;
  sb_t sb_q[$];

  typedef struct { string name; logic [7:0] tx; logic [1:0] mode; logic [7:0] pat; logic [7:0] rx_exp; } vec_t;
  vec_t vecs[5];

  spi_master_engine #(.DATA_SIZE(8), .CLK_DIV(2)) dut_a (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_a),
    .busy(busy_a), .done_sig(done_a), .rx_data(rx_a), .ss_out(ss_a),
    .sclk_out(sclk_a), .mosi_out(mosi_a), .miso_in(miso_a)
  );

  spi_master_engine #(.DATA_SIZE(4), .CLK_DIV(1)) dut_b (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_b),
    .busy(busy_b), .done_sig(done_b), .rx_data(rx_b), .ss_out(ss_b),
    .sclk_out(sclk_b), .mosi_out(mosi_b), .miso_in(mosi_b)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  assign slave_bit = (slave_idx < 8) ? slave_pat[7 - slave_idx] : 1'b0;

  always_comb begin
    case (miso_mode)
      2'd0:    miso_a = mosi_a;
      2'd1:    miso_a = 1'b1;
      2'd2:    miso_a = 1'b0;
      default: miso_a = slave_bit;
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Slave model: restarts on SS rise, advances one bit after each SCLK fall.
  initial begin
    logic prev_ss, prev_sclk;
    prev_ss = 1'b0;
    prev_sclk = 1'b0;
    slave_idx = 8;
    forever begin
      @(negedge sys_clk);
      if (ss_a && !prev_ss) slave_idx = 0;
      else if (prev_sclk && !sclk_a && slave_idx < 8) slave_idx = slave_idx + 1;
      prev_ss = ss_a;
      prev_sclk = sclk_a;
    end
  end

  // Monitor and scoreboard for instance A.
  initial begin
    int rises, ss_hi, busy_hi;
    logic p_ss, p_sclk, p_busy, p_mosi, exp_bit;
    sb_t item;
    rises = 0; ss_hi = 0; busy_hi = 0;
    p_ss = 1'b0; p_sclk = 1'b0; p_busy = 1'b0; p_mosi = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (!rst_n) begin
        rises = 0; ss_hi = 0; busy_hi = 0;
        p_ss = 1'b0; p_sclk = 1'b0; p_busy = 1'b0; p_mosi = 1'b0;
      end else begin
        if (ss_a) ss_hi++;
        if (busy_a) busy_hi++;
        if (!p_sclk && sclk_a) begin
          if (sb_q.size() > 0 && rises < 8) begin
            exp_bit = sb_q[0].tx[7 - rises];
            check("mosi_at_rise", {31'd0, mosi_a}, {31'd0, exp_bit});
            check("mosi_before_rise", {31'd0, p_mosi}, {31'd0, exp_bit});
          end
          rises++;
        end
        if (done_a) begin
          done_cnt++;
          check("done_with_ss_fall", {30'd0, p_ss, ss_a}, 32'd2);
          check("mosi_zero_after_ss", {31'd0, mosi_a}, 32'd0);
          check("sclk_rise_count", rises, 32'd8);
          check("ss_high_cycles", ss_hi, 32'd34);
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done_sig with rx %0h, expected none", rx_a);
          end else begin
            item = sb_q.pop_front();
            check("rx_scoreboard", {24'd0, rx_a}, {24'd0, item.rx});
          end
        end
        if (p_busy && !busy_a) begin
          check("busy_high_cycles", busy_hi, 32'd36);
          rises = 0; ss_hi = 0; busy_hi = 0;
        end
        p_ss = ss_a; p_sclk = sclk_a; p_busy = busy_a; p_mosi = mosi_a;
      end
    end
  end

  int b_hi_runs = 0;
  int b_lo_runs = 0;
  int b_done = 0;

  // Monitor for instance B: SS high/low run lengths between transfers.
  initial begin
    int hi, lo;
    logic p_ss, seen;
    hi = 0; lo = 0; p_ss = 1'b0; seen = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (rst_n) begin
        if (done_b) b_done++;
        if (ss_b) hi++;
        if (!ss_b && seen) lo++;
        if (p_ss && !ss_b) begin
          check("b2b_ss_high", hi, 32'd9);
          b_hi_runs++;
          hi = 0;
          seen = 1'b1;
          lo = 1;
        end
        if (!p_ss && ss_b && seen) begin
          check("b2b_ss_low", lo, 32'd2);
          b_lo_runs++;
          lo = 0;
        end
        p_ss = ss_b;
      end
    end
  end

  task automatic run_a(input logic [7:0] tx, input logic [7:0] rx_exp);
    sb_t item;
    item.tx = tx;
    item.rx = rx_exp;
    @(posedge sys_clk);
    #1;
    tx_a = tx;
    start_a = 1'b1;
    sb_q.push_back(item);
    @(posedge sys_clk);
    #1;
    start_a = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (busy_a && n < 200);
    check("idle_timeout_a", {31'd0, busy_a}, 32'd0);
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin
    int d0;
    int n;
    rst_n = 1'b0;
    start_a = 1'b0; tx_a = 8'h00;
    start_b = 1'b0; tx_b = 4'h0;
    miso_mode = 2'd0;
    slave_pat = 8'h00;

    vecs[0] = '{name: "loopback_a5",   tx: 8'hA5, mode: 2'd0, pat: 8'h00, rx_exp: 8'hA5};
    vecs[1] = '{name: "miso_one",      tx: 8'h00, mode: 2'd1, pat: 8'h00, rx_exp: 8'hFF};
    vecs[2] = '{name: "miso_zero",     tx: 8'hFF, mode: 2'd2, pat: 8'h00, rx_exp: 8'h00};
    vecs[3] = '{name: "slave_3c",      tx: 8'h96, mode: 2'd3, pat: 8'h3C, rx_exp: 8'h3C};
    vecs[4] = '{name: "slave_c3",      tx: 8'h3C, mode: 2'd3, pat: 8'hC3, rx_exp: 8'hC3};

    repeat (3) @(negedge sys_clk);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_rx", {24'd0, rx_a}, 32'd0);
    check("rst_ss", {31'd0, ss_a}, 32'd0);
    check("rst_sclk", {31'd0, sclk_a}, 32'd0);
    check("rst_mosi", {31'd0, mosi_a}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    for (int i = 0; i < 5; i++) begin
      miso_mode = vecs[i].mode;
      slave_pat = vecs[i].pat;
      d0 = done_cnt;
      run_a(vecs[i].tx, vecs[i].rx_exp);
      wait_idle_a();
      check(vecs[i].name, {24'd0, rx_a}, {24'd0, vecs[i].rx_exp});
      check("one_done_pulse", done_cnt - d0, 32'd1);
    end

    // start pulsed mid-transfer must be ignored.
    miso_mode = 2'd0;
    d0 = done_cnt;
    run_a(8'hA5, 8'hA5);
    repeat (9) @(posedge sys_clk);
    #1;
    tx_a = 8'h11;
    start_a = 1'b1;
    @(posedge sys_clk);
    #1;
    start_a = 1'b0;
    wait_idle_a();
    repeat (40) @(negedge sys_clk);
    check("busy_start_one_done", done_cnt - d0, 32'd1);
    check("busy_start_rx", {24'd0, rx_a}, 32'hA5);
    check("busy_start_idle", {31'd0, busy_a}, 32'd0);

    // Reset mid-transfer aborts asynchronously with no completion.
    d0 = done_cnt;
    run_a(8'hC3, 8'hC3);
    repeat (15) @(posedge sys_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ss", {31'd0, ss_a}, 32'd0);
    check("abort_sclk", {31'd0, sclk_a}, 32'd0);
    check("abort_busy", {31'd0, busy_a}, 32'd0);
    check("abort_rx", {24'd0, rx_a}, 32'd0);
    repeat (3) @(posedge sys_clk);
    #2;
    rst_n = 1'b1;
    sb_q.delete();
    repeat (40) @(negedge sys_clk);
    check("abort_no_done", done_cnt - d0, 32'd0);
    run_a(8'h5A, 8'h5A);
    wait_idle_a();
    check("after_abort_rx", {24'd0, rx_a}, 32'h5A);
    check("after_abort_done", done_cnt - d0, 32'd1);

    // Back-to-back transfers with start held high.
    @(posedge sys_clk);
    #1;
    tx_b = 4'h9;
    start_b = 1'b1;
    n = 0;
    while (b_hi_runs < 3 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    start_b = 1'b0;
    check("b2b_run_timeout", b_hi_runs, 32'd3);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (busy_b && n < 100);
    check("idle_timeout_b", {31'd0, busy_b}, 32'd0);
    repeat (10) @(negedge sys_clk);
    check("b2b_rx", {28'd0, rx_b}, 32'h9);
    check("b2b_high_runs", b_hi_runs, 32'd3);
    check("b2b_low_runs", b_lo_runs, 32'd2);
    check("b2b_done_count", b_done, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
